// File: rtl/maze_pkg.sv
// Shared maze definitions: tile values, default geometry, mode and requester encodings,
// and the read-return tag carried down the two-stage pipeline.
package maze_pkg;

   localparam logic FLOOR = 1'b0;
   localparam logic WALL  = 1'b1;

   localparam int MAZE_WIDTH   = 30;
   localparam int MAZE_HEIGHT  = 40;
   localparam int MAZE_COORD_W = 6;
   localparam int MAZE_ADDR_W  = 11;

   typedef enum logic {
      MODE_GEN = 1'b0,
      MODE_RUN = 1'b1
   } mode_e;

   typedef enum logic [1:0] {
      REQ_NONE    = 2'd0,
      REQ_GEN     = 2'd1,
      REQ_PLAYER  = 2'd2,
      REQ_DISPLAY = 2'd3
   } req_id_e;

   typedef struct packed {
      req_id_e owner;
      logic    force_wall;
   } rd_tag_t;

   localparam rd_tag_t TAG_IDLE = '{owner: REQ_NONE, force_wall: 1'b0};

endpackage

// File: rtl/maze_ram_arbiter_if.sv
// Requester and RAM-side signals of the maze RAM arbiter; the slave modport is the
// arbiter view, the master modport is the view of the surrounding system.
interface maze_ram_arbiter_if
   import maze_pkg::*;
#(
   parameter int COORD_W = MAZE_COORD_W,
   parameter int ADDR_W  = MAZE_ADDR_W
);

   logic               gen_start, gen_done;
   logic               gen_req, gen_gnt, gen_data;
   logic [COORD_W-1:0] gen_x, gen_y;
   logic               p_req, p_gnt, p_rvalid, p_rdata;
   logic [COORD_W-1:0] p_x, p_y;
   logic               d_req, d_gnt, d_rvalid, d_rdata;
   logic [COORD_W-1:0] d_x, d_y;
   logic [ADDR_W-1:0]  ram_address;
   logic               ram_data, ram_wren, ram_q;

   modport slave (
      input  gen_start, gen_done,
      input  gen_req, gen_x, gen_y, gen_data,
      output gen_gnt,
      input  p_req, p_x, p_y,
      output p_gnt, p_rvalid, p_rdata,
      input  d_req, d_x, d_y,
      output d_gnt, d_rvalid, d_rdata,
      output ram_address, ram_data, ram_wren,
      input  ram_q
   );

   modport master (
      output gen_start, gen_done,
      output gen_req, gen_x, gen_y, gen_data,
      input  gen_gnt,
      output p_req, p_x, p_y,
      input  p_gnt, p_rvalid, p_rdata,
      output d_req, d_x, d_y,
      input  d_gnt, d_rvalid, d_rdata,
      input  ram_address, ram_data, ram_wren,
      output ram_q
   );

endinterface

// File: rtl/maze_coord_addr.sv
// Row-major tile address (WIDTH*y + x) and bounds check for one coordinate pair.
module maze_coord_addr
   import maze_pkg::*;
#(
   parameter int WIDTH   = MAZE_WIDTH,
   parameter int HEIGHT  = MAZE_HEIGHT,
   parameter int COORD_W = MAZE_COORD_W,
   parameter int ADDR_W  = MAZE_ADDR_W
) (
   input  logic [COORD_W-1:0] x_i,
   input  logic [COORD_W-1:0] y_i,
   output logic [ADDR_W-1:0]  addr_o,
   output logic               in_range_o
);

   assign addr_o     = ADDR_W'(WIDTH) * ADDR_W'(y_i) + ADDR_W'(x_i);
   assign in_range_o = (int'(x_i) < WIDTH) && (int'(y_i) < HEIGHT);

endmodule

// File: rtl/maze_ram_arbiter.sv
// Single-port maze RAM controller: arbitrates generator writes against two reader ports
// and returns read data (or a forced WALL) to the granted reader two cycles later.
module maze_ram_arbiter
   import maze_pkg::*;
#(
   parameter int WIDTH   = MAZE_WIDTH,
   parameter int HEIGHT  = MAZE_HEIGHT,
   parameter int COORD_W = MAZE_COORD_W,
   parameter int ADDR_W  = MAZE_ADDR_W
) (
   input logic               clock,
   input logic               reset,
   maze_ram_arbiter_if.slave bus
);

   mode_e              mode_q, mode_d;
   logic               run_mode;
   req_id_e            rr_last_q;
   logic               gen_gnt, p_gnt, d_gnt;
   logic [COORD_W-1:0] sel_x, sel_y;
   logic [ADDR_W-1:0]  addr, ram_address_q;
   logic               in_range, issue_write, issue_read;
   logic               ram_data_q, ram_wren_q;
   rd_tag_t            grant_tag, tag1_q, tag2_q;
   logic               rd_value, p_rvalid, d_rvalid, p_rdata, d_rdata;
   logic               p_rdata_q, d_rdata_q;

   // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clock) begin
      if (reset) mode_q <= MODE_GEN;
      else       mode_q <= mode_d;
   end

   always_comb begin
      mode_d = mode_q;
      case (mode_q)
         MODE_GEN: if (bus.gen_done && !bus.gen_start) mode_d = MODE_RUN;
         MODE_RUN: if (bus.gen_start) mode_d = MODE_GEN;
      endcase
   end

   always_comb run_mode = (mode_q == MODE_RUN);

   // NOTE: every combinational output gets a default first so no path can infer a latch.
   always_comb begin
      gen_gnt = 1'b0;
      p_gnt   = 1'b0;
      d_gnt   = 1'b0;
      if (!reset) begin
         if (bus.gen_req)                                        gen_gnt = 1'b1;
         else if (bus.p_req && (!bus.d_req || rr_last_q == REQ_DISPLAY)) p_gnt = 1'b1;
         else if (bus.d_req)                                     d_gnt   = 1'b1;
      end
   end

   always_comb begin
      sel_x = bus.p_x;
      sel_y = bus.p_y;
      if (gen_gnt) begin
         sel_x = bus.gen_x;
         sel_y = bus.gen_y;
      end else if (d_gnt) begin
         sel_x = bus.d_x;
         sel_y = bus.d_y;
      end
   end

   maze_coord_addr #(
      .WIDTH   (WIDTH),
      .HEIGHT  (HEIGHT),
      .COORD_W (COORD_W),
      .ADDR_W  (ADDR_W)
   ) u_coord_addr (
      .x_i        (sel_x),
      .y_i        (sel_y),
      .addr_o     (addr),
      .in_range_o (in_range)
   );

   assign issue_write = gen_gnt && in_range;
   assign issue_read  = (p_gnt || d_gnt) && in_range && run_mode;

   // The tag fixes the outcome at grant time, so later mode changes cannot alter it.
   always_comb begin
      grant_tag = TAG_IDLE;
      if (p_gnt)      grant_tag.owner = REQ_PLAYER;
      else if (d_gnt) grant_tag.owner = REQ_DISPLAY;
      grant_tag.force_wall = !(in_range && run_mode);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         rr_last_q     <= REQ_DISPLAY;
         tag1_q        <= TAG_IDLE;
         tag2_q        <= TAG_IDLE;
         ram_address_q <= '0;
         ram_data_q    <= 1'b0;
         ram_wren_q    <= 1'b0;
         p_rdata_q     <= 1'b0;
         d_rdata_q     <= 1'b0;
      end else begin
         if (p_gnt)      rr_last_q <= REQ_PLAYER;
         else if (d_gnt) rr_last_q <= REQ_DISPLAY;
         tag1_q <= grant_tag;
         tag2_q <= tag1_q;
         if (issue_write || issue_read) ram_address_q <= addr;
         if (issue_write)               ram_data_q    <= bus.gen_data;
         ram_wren_q <= issue_write;
         p_rdata_q  <= p_rdata;
         d_rdata_q  <= d_rdata;
      end
   end

   // ram_q is valid while tag2 is current; non-owners keep their previous data.
   always_comb begin
      rd_value = tag2_q.force_wall ? WALL : bus.ram_q;
      p_rvalid = !reset && (tag2_q.owner == REQ_PLAYER);
      d_rvalid = !reset && (tag2_q.owner == REQ_DISPLAY);
      p_rdata  = p_rvalid ? rd_value : p_rdata_q;
      d_rdata  = d_rvalid ? rd_value : d_rdata_q;
   end

   assign bus.gen_gnt     = gen_gnt;
   assign bus.p_gnt       = p_gnt;
   assign bus.d_gnt       = d_gnt;
   assign bus.p_rvalid    = p_rvalid;
   assign bus.d_rvalid    = d_rvalid;
   assign bus.p_rdata     = p_rdata;
   assign bus.d_rdata     = d_rdata;
   assign bus.ram_address = ram_address_q;
   assign bus.ram_data    = ram_data_q;
   assign bus.ram_wren    = ram_wren_q;

endmodule

// File: tb/tb_maze_ram_arbiter.sv
// Self-checking bench for maze_ram_arbiter: directed vector table, reset sequences and
// randomized traffic, all compared against a transaction-level model with its own RAM image.
module tb_maze_ram_arbiter;
   import maze_pkg::*;

   localparam int W  = 30;
   localparam int H  = 40;
   localparam int CW = 6;
   localparam int AW = 11;

   logic clock = 1'b0;
   logic reset = 1'b1;
   always #5 clock = ~clock;

   maze_ram_arbiter_if #(.COORD_W(CW), .ADDR_W(AW)) bus ();

   maze_ram_arbiter #(
      .WIDTH   (W),
      .HEIGHT  (H),
      .COORD_W (CW),
      .ADDR_W  (AW)
   ) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   // Behavioural maze RAM with registered read data.
   logic ram_mem [0:(2**AW)-1];
   always @(posedge clock) begin
      if (bus.ram_wren) ram_mem[bus.ram_address] <= bus.ram_data;
      bus.ram_q <= ram_mem[bus.ram_address];
   end

   typedef struct {
      logic gen_start, gen_done;
      logic gen_req;
      int   gx, gy;
      logic gdata;
      logic p_req;
      int   px, py;
      logic d_req;
      int   dx, dy;
   } stim_t;

   typedef struct {
      stim_t s;
      logic  eg, ep, ed;
      bit    cr;
      logic  ew;
      int    ea;
      bit    cv;
      logic  epv, edv, erd;
   } vec_t;

   typedef struct {
      int   due;
      int   who;
      logic val;
   } pend_t;

   int    n_checks = 0;
   int    n_errors = 0;
   int    cyc = 0;
   bit    m_run;
   bit    m_last_p;
   logic  ref_mem [0:(2**AW)-1];
   logic  e_wren, e_data, e_prd, e_drd;
   int    e_addr;
   logic  e_prv, e_drv;
   pend_t pend[$];
   vec_t  vecs[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic check_bit(input string name, input logic act, input logic exp);
      check(name, {31'd0, act}, {31'd0, exp});
   endtask

   function automatic stim_t st(input logic gs, gdn, gr, input int gx, gy, input logic gd,
                                input logic pr, input int px, py,
                                input logic dr, input int dx, dy);
      stim_t s;
      s.gen_start = gs; s.gen_done = gdn;
      s.gen_req = gr; s.gx = gx; s.gy = gy; s.gdata = gd;
      s.p_req = pr; s.px = px; s.py = py;
      s.d_req = dr; s.dx = dx; s.dy = dy;
      return s;
   endfunction

   function automatic stim_t idle();
      return st(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   endfunction

   function automatic vec_t v(input stim_t s, input logic eg, ep, ed,
                              input bit cr = 0, input logic ew = 0, input int ea = 0,
                              input bit cv = 0, input logic epv = 0, edv = 0, erd = 0);
      vec_t r;
      r.s = s; r.eg = eg; r.ep = ep; r.ed = ed;
      r.cr = cr; r.ew = ew; r.ea = ea;
      r.cv = cv; r.epv = epv; r.edv = edv; r.erd = erd;
      return r;
   endfunction

   task automatic drive(input stim_t s);
      bus.gen_start = s.gen_start;
      bus.gen_done  = s.gen_done;
      bus.gen_req   = s.gen_req;
      bus.gen_x     = CW'(s.gx);
      bus.gen_y     = CW'(s.gy);
      bus.gen_data  = s.gdata;
      bus.p_req     = s.p_req;
      bus.p_x       = CW'(s.px);
      bus.p_y       = CW'(s.py);
      bus.d_req     = s.d_req;
      bus.d_x       = CW'(s.dx);
      bus.d_y       = CW'(s.dy);
   endtask

   task automatic model_reset();
      m_run = 0; m_last_p = 0;
      e_wren = 0; e_data = 0; e_addr = 0; e_prd = 0; e_drd = 0;
      pend.delete();
   endtask

   // Drive one cycle, wait for the falling edge and compare everything against the model.
   task automatic begin_cycle(input stim_t s, output logic eg, ep, ed);
      drive(s);
      eg = s.gen_req;
      ep = !eg && s.p_req && (!s.d_req || !m_last_p);
      ed = !eg && s.d_req && !ep;
      e_prv = 0; e_drv = 0;
      while (pend.size() > 0 && pend[0].due <= cyc) begin
         if (pend[0].due == cyc) begin
            if (pend[0].who == 1) begin e_prv = 1; e_prd = pend[0].val; end
            else                  begin e_drv = 1; e_drd = pend[0].val; end
         end
         void'(pend.pop_front());
      end
      @(negedge clock);
      check_bit("gen_gnt", bus.gen_gnt, eg);
      check_bit("p_gnt", bus.p_gnt, ep);
      check_bit("d_gnt", bus.d_gnt, ed);
      check_bit("ram_wren", bus.ram_wren, e_wren);
      check("ram_address", 32'(bus.ram_address), e_addr);
      check_bit("ram_data", bus.ram_data, e_data);
      check_bit("p_rvalid", bus.p_rvalid, e_prv);
      check_bit("d_rvalid", bus.d_rvalid, e_drv);
      check_bit("p_rdata", bus.p_rdata, e_prd);
      check_bit("d_rdata", bus.d_rdata, e_drd);
   endtask

   // Apply this cycle's grant to the model, then move to just after the next rising edge.
   task automatic end_cycle(input stim_t s, input logic eg, ep, ed);
      int   x, y, a;
      bit   inr;
      logic val;
      e_wren = 0;
      if (eg || ep || ed) begin
         x = eg ? s.gx : (ep ? s.px : s.dx);
         y = eg ? s.gy : (ep ? s.py : s.dy);
         inr = (x < W) && (y < H);
         a = W * y + x;
         if (eg) begin
            if (inr) begin
               ref_mem[a] = s.gdata;
               e_wren = 1; e_addr = a; e_data = s.gdata;
            end
         end else begin
            val = WALL;
            if (inr && m_run) begin
               val = ref_mem[a];
               e_addr = a;
            end
            pend.push_back('{due: cyc + 2, who: (ep ? 1 : 2), val: val});
         end
      end
      if (s.gen_start)     m_run = 0;
      else if (s.gen_done) m_run = 1;
      if (ep)      m_last_p = 1;
      else if (ed) m_last_p = 0;
      @(posedge clock);
      #1;
      cyc++;
   endtask

   // Two-cycle reset with every request asserted; checks the reset state mid-way.
   task automatic do_reset();
      reset = 1'b1;
      drive(st(1, 1, 1, 1, 1, 1, 1, 2, 2, 1, 3, 3));
      @(posedge clock);
      #1;
      @(negedge clock);
      check_bit("rst_gen_gnt", bus.gen_gnt, 1'b0);
      check_bit("rst_p_gnt", bus.p_gnt, 1'b0);
      check_bit("rst_d_gnt", bus.d_gnt, 1'b0);
      check_bit("rst_p_rvalid", bus.p_rvalid, 1'b0);
      check_bit("rst_d_rvalid", bus.d_rvalid, 1'b0);
      check_bit("rst_p_rdata", bus.p_rdata, 1'b0);
      check_bit("rst_d_rdata", bus.d_rdata, 1'b0);
      check("rst_ram_address", 32'(bus.ram_address), 32'd0);
      check_bit("rst_ram_data", bus.ram_data, 1'b0);
      check_bit("rst_ram_wren", bus.ram_wren, 1'b0);
      @(posedge clock);
      #1;
      reset = 1'b0;
      drive(idle());
      cyc += 2;
      model_reset();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic  eg, ep, ed;
      stim_t cur;

      for (int i = 0; i < 2**AW; i++) begin
         ram_mem[i] = 1'($urandom_range(0, 1));
      end
      ram_mem[0] = FLOOR; ram_mem[62] = WALL; ram_mem[63] = WALL; ram_mem[64] = FLOOR;
      for (int i = 0; i < 2**AW; i++) ref_mem[i] = ram_mem[i];

      // gs gd gr  gx gy d  pr px py dr dx dy
      vecs.push_back(v(st(0,1, 0, 0, 0,0, 0, 0, 0, 0, 0, 0), 0,0,0));
      vecs.push_back(v(st(0,0, 0, 0, 0,0, 1, 3, 2, 0, 0, 0), 0,1,0));
      vecs.push_back(v(idle(), 0,0,0, 1, 0, 63));
      vecs.push_back(v(idle(), 0,0,0, 0, 0, 0, 1, 1, 0, 1));
      vecs.push_back(v(st(0,0, 0, 0, 0,0, 0, 0, 0, 1, 4, 4), 0,0,1));
      vecs.push_back(v(st(0,0, 1, 5, 5,0, 1, 1, 1, 1, 2, 2), 1,0,0));
      vecs.push_back(v(st(0,0, 0, 0, 0,0, 1, 1, 1, 1, 2, 2), 0,1,0, 1, 1, 155));
      vecs.push_back(v(st(0,0, 0, 0, 0,0, 1, 6, 1, 1, 2, 2), 0,0,1));
      vecs.push_back(v(st(0,0, 0, 0, 0,0, 1, 6, 1, 1, 7, 7), 0,1,0));
      vecs.push_back(v(st(0,0, 1,29,39,1, 0, 0, 0, 0, 0, 0), 1,0,0));
      vecs.push_back(v(st(0,0, 1,30, 0,1, 0, 0, 0, 0, 0, 0), 1,0,0, 1, 1, 1199));
      vecs.push_back(v(idle(), 0,0,0, 1, 0, 1199));
      vecs.push_back(v(idle(), 0,0,0));
      vecs.push_back(v(st(1,0, 0, 0, 0,0, 0, 0, 0, 0, 0, 0), 0,0,0));
      vecs.push_back(v(st(0,0, 0, 0, 0,0, 0, 0, 0, 1, 0, 0), 0,0,1));
      vecs.push_back(v(idle(), 0,0,0, 1, 0, 1199));
      vecs.push_back(v(idle(), 0,0,0, 0, 0, 0, 1, 0, 1, 1));
      vecs.push_back(v(st(0,0, 1, 7, 3,0, 0, 0, 0, 0, 0, 0), 1,0,0));
      vecs.push_back(v(st(0,1, 0, 0, 0,0, 0, 0, 0, 0, 0, 0), 0,0,0, 1, 1, 97));
      vecs.push_back(v(st(0,0, 0, 0, 0,0, 1, 7, 3, 0, 0, 0), 0,1,0));
      vecs.push_back(v(idle(), 0,0,0));
      vecs.push_back(v(idle(), 0,0,0, 0, 0, 0, 1, 1, 0, 0));
      vecs.push_back(v(st(0,0, 0, 0, 0,0, 1, 4, 2, 0, 0, 0), 0,1,0));
      vecs.push_back(v(st(1,0, 0, 0, 0,0, 0, 0, 0, 0, 0, 0), 0,0,0, 1, 0, 64));
      vecs.push_back(v(idle(), 0,0,0, 0, 0, 0, 1, 1, 0, 0));
      vecs.push_back(v(st(0,1, 0, 0, 0,0, 0, 0, 0, 0, 0, 0), 0,0,0));
      vecs.push_back(v(st(1,1, 0, 0, 0,0, 0, 0, 0, 0, 0, 0), 0,0,0));
      vecs.push_back(v(st(0,0, 0, 0, 0,0, 1, 4, 2, 0, 0, 0), 0,1,0));
      vecs.push_back(v(idle(), 0,0,0));
      vecs.push_back(v(idle(), 0,0,0, 0, 0, 0, 1, 1, 0, 1));
      vecs.push_back(v(st(0,1, 0, 0, 0,0, 0, 0, 0, 0, 0, 0), 0,0,0));
      vecs.push_back(v(st(0,0, 0, 0, 0,0, 0, 0, 0, 1, 0,40), 0,0,1));
      vecs.push_back(v(idle(), 0,0,0));
      vecs.push_back(v(idle(), 0,0,0, 0, 0, 0, 1, 0, 1, 1));

      drive(idle());
      do_reset();

      foreach (vecs[i]) begin
         begin_cycle(vecs[i].s, eg, ep, ed);
         check_bit("tbl_gen_gnt", bus.gen_gnt, vecs[i].eg);
         check_bit("tbl_p_gnt", bus.p_gnt, vecs[i].ep);
         check_bit("tbl_d_gnt", bus.d_gnt, vecs[i].ed);
         if (vecs[i].cr) begin
            check_bit("tbl_ram_wren", bus.ram_wren, vecs[i].ew);
            check("tbl_ram_address", 32'(bus.ram_address), vecs[i].ea);
         end
         if (vecs[i].cv) begin
            check_bit("tbl_p_rvalid", bus.p_rvalid, vecs[i].epv);
            check_bit("tbl_d_rvalid", bus.d_rvalid, vecs[i].edv);
            check_bit("tbl_rdata", vecs[i].epv ? bus.p_rdata : bus.d_rdata, vecs[i].erd);
         end
         end_cycle(vecs[i].s, eg, ep, ed);
      end

      // Reset landing between a read grant and its data return.
      cur = st(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      begin_cycle(cur, eg, ep, ed);
      end_cycle(cur, eg, ep, ed);
      cur = st(0, 0, 0, 0, 0, 0, 1, 3, 2, 0, 0, 0);
      begin_cycle(cur, eg, ep, ed);
      check_bit("mid_p_gnt", bus.p_gnt, 1'b1);
      end_cycle(cur, eg, ep, ed);
      do_reset();
      cur = st(0, 0, 0, 0, 0, 0, 1, 3, 2, 1, 5, 5);
      begin_cycle(cur, eg, ep, ed);
      check_bit("post_rst_p_first", bus.p_gnt, 1'b1);
      end_cycle(cur, eg, ep, ed);

      // Randomized traffic; each requester holds its request until granted.
      cur = idle();
      for (int i = 0; i < 1500; i++) begin
         if (i % 500 == 250) begin
            do_reset();
            cur = idle();
         end
         if (!cur.gen_req && $urandom_range(0, 3) == 0) begin
            cur.gen_req = 1; cur.gdata = 1'($urandom_range(0, 1));
            cur.gx = $urandom_range(0, 34); cur.gy = $urandom_range(0, 44);
         end
         if (!cur.p_req && $urandom_range(0, 1) == 0) begin
            cur.p_req = 1; cur.px = $urandom_range(0, 34); cur.py = $urandom_range(0, 44);
         end
         if (!cur.d_req && $urandom_range(0, 1) == 0) begin
            cur.d_req = 1;
            cur.dx = ($urandom_range(0, 15) == 0) ? 63 : $urandom_range(0, 31);
            cur.dy = ($urandom_range(0, 15) == 0) ? 63 : $urandom_range(0, 41);
         end
         cur.gen_start = ($urandom_range(0, 31) == 0);
         cur.gen_done  = ($urandom_range(0, 9) == 0);
         begin_cycle(cur, eg, ep, ed);
         end_cycle(cur, eg, ep, ed);
         if (eg) cur.gen_req = 0;
         if (ep) cur.p_req = 0;
         if (ed) cur.d_req = 0;
      end

      drive(idle());
      for (int i = 0; i < 3; i++) begin
         begin_cycle(idle(), eg, ep, ed);
         end_cycle(idle(), eg, ep, ed);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
